i2c_cfg_sequencer: RTL

//  Walks a combinational sensor-config LUT ({reg_addr, reg_data} entries) and drives an I2C master.

---
 rtl/i2c_cfg_pkg.sv | 16 +
 rtl/cfg_delay_timer.sv | 18 +
 rtl/i2c_cfg_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/i2c_cfg_pkg.sv
// i2c_cfg_pkg: shared state encoding, command constants and counter sizing for the I2C config sequencer
package i2c_cfg_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_PWRUP, S_FETCH, S_ISSUE, S_WAIT_RSP, S_VRD_ISSUE, S_VRD_WAIT,
    S_NEXT, S_DELAY, S_DONE, S_ERROR
  } state_t;
  localparam logic CMD_WR = 1'b0;
  localparam logic CMD_RD = 1'b1;
  localparam int DLY_ADDR = 0;
  function automatic int cnt_width(input longint a, input longint b, input longint c);
    longint m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return m < 2 ? 1 : $clog2(m + 64'd1);
  endfunction
endpackage

// File: rtl/cfg_delay_timer.sv
// cfg_delay_timer: loadable down-counter, expired while it sits at zero
module cfg_delay_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - CNT_W'(1);
  end
  assign expired = cnt == '0;
endmodule

// File: rtl/i2c_cfg_sequencer.sv
// i2c_cfg_sequencer: walks a {addr, data} config LUT and drives an I2C master with ID check, verify and retry
module i2c_cfg_sequencer
  import i2c_cfg_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int IDX_W      = 8,
  parameter int DLY_CYC    = 200000,
  parameter int DLY_UNIT   = 1000,
  parameter int PWRUP_CYC  = 20000,
  parameter int MAX_RETRY  = 3,
  parameter int ID_CHECK   = 1,
  parameter int VERIFY     = 0,
  parameter int AUTO_START = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_start,
  output logic [IDX_W-1:0]         lut_index,
  input  logic [ADDR_W+DATA_W-1:0] lut_data,
  input  logic [IDX_W-1:0]         lut_size,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic                     cmd_rw,
  output logic [ADDR_W-1:0]        cmd_addr,
  output logic [DATA_W-1:0]        cmd_wdata,
  input  logic                     rsp_valid,
  input  logic                     rsp_nack,
  input  logic [DATA_W-1:0]        rsp_rdata,
  output logic                     cfg_busy,
  output logic                     cfg_done,
  output logic                     cfg_err,
  output logic [IDX_W-1:0]         err_index
);
  localparam int CNT_W = cnt_width(longint'(PWRUP_CYC), longint'(DLY_CYC),
                                   ((64'd1 << DATA_W) - 64'd1) * longint'(DLY_UNIT));
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [CNT_W-1:0] PWRUP_VAL = CNT_W'(PWRUP_CYC > 0 ? PWRUP_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] DLY_VAL = CNT_W'(DLY_CYC > 0 ? DLY_CYC - 1 : 0);
  state_t state, state_nxt;
  logic [RW-1:0] retry;
  logic auto_pend, tmr_load, tmr_exp, is_dly, bad, retry_ok;
  logic [CNT_W-1:0] tmr_val, dly_val;
  logic [ADDR_W-1:0] lut_addr;
  logic [DATA_W-1:0] lut_dat;
  logic [IDX_W-1:0] idx_inc;
  assign lut_addr = lut_data[ADDR_W+DATA_W-1:DATA_W];
  assign lut_dat = lut_data[DATA_W-1:0];
  assign idx_inc = lut_index + IDX_W'(1);
  assign is_dly = lut_addr == ADDR_W'(DLY_ADDR) && lut_index != '0;
  assign dly_val = lut_dat == '0 ? DLY_VAL : CNT_W'(lut_dat) * CNT_W'(DLY_UNIT) - CNT_W'(1);
  // only reads (ID check or read-back) carry data to compare
  assign bad = rsp_nack || (cmd_rw == CMD_RD && rsp_rdata != cmd_wdata);
  assign retry_ok = retry < RW'(MAX_RETRY);
  cfg_delay_timer #(.CNT_W(CNT_W)) u_tmr (
    .clk(clk), .rst(rst), .load(tmr_load), .load_val(tmr_val), .expired(tmr_exp)
  );
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    tmr_load = 1'b0;
    tmr_val = PWRUP_VAL;
    cmd_valid = 1'b0;
    case (state)
      S_IDLE: if (cfg_start || auto_pend) begin
        state_nxt = S_PWRUP;
        tmr_load = 1'b1;
      end
      S_PWRUP: if (tmr_exp) state_nxt = lut_size == '0 ? S_DONE : S_FETCH;
      S_FETCH: begin
        state_nxt = is_dly ? S_DELAY : S_ISSUE;
        tmr_load = is_dly;
        tmr_val = dly_val;
      end
      S_ISSUE: begin
        cmd_valid = 1'b1;
        if (cmd_ready) state_nxt = S_WAIT_RSP;
      end
      S_VRD_ISSUE: begin
        cmd_valid = 1'b1;
        if (cmd_ready) state_nxt = S_VRD_WAIT;
      end
      S_WAIT_RSP, S_VRD_WAIT: if (rsp_valid)
        state_nxt = bad ? (retry_ok ? S_ISSUE : S_ERROR) :
                    (state == S_WAIT_RSP && VERIFY != 0 && cmd_rw == CMD_WR) ? S_VRD_ISSUE : S_NEXT;
      S_DELAY: if (tmr_exp) state_nxt = S_NEXT;
      S_NEXT: state_nxt = idx_inc == lut_size ? S_DONE : S_FETCH;
      default: state_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      auto_pend <= AUTO_START != 0;
      lut_index <= '0;
      retry <= '0;
      cmd_rw <= CMD_WR;
      cmd_addr <= '0;
      cmd_wdata <= '0;
      cfg_busy <= 1'b0;
      cfg_done <= 1'b0;
      cfg_err <= 1'b0;
      err_index <= '0;
    end else begin
      auto_pend <= 1'b0;
      if (state == S_IDLE && state_nxt == S_PWRUP) begin
        cfg_busy <= 1'b1;
        cfg_done <= 1'b0;
        cfg_err <= 1'b0;
        err_index <= '0;
        lut_index <= '0;
        retry <= '0;
      end
      if (state == S_FETCH) begin
        cmd_addr <= lut_addr;
        cmd_wdata <= lut_dat;
        cmd_rw <= (ID_CHECK != 0 && lut_index == '0) ? CMD_RD : CMD_WR;
      end
      if (state_nxt == S_VRD_ISSUE) cmd_rw <= CMD_RD;
      if (state == S_VRD_WAIT && state_nxt == S_ISSUE) cmd_rw <= CMD_WR;
      if ((state == S_WAIT_RSP || state == S_VRD_WAIT) && rsp_valid && bad) retry <= retry + RW'(1);
      if (state == S_NEXT) begin
        retry <= '0;
        lut_index <= idx_inc;
      end
      if (state == S_DONE) begin
        cfg_done <= 1'b1;
        cfg_busy <= 1'b0;
      end
      if (state == S_ERROR) begin
        cfg_err <= 1'b1;
        err_index <= lut_index;
        cfg_busy <= 1'b0;
      end
    end
  end
endmodule
